// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus width defaults and the MEM-stage sequencer state encoding.
package cpu_pkg;

  localparam int CPU_DATA_WIDTH = 16;
  localparam int CPU_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating wait-cycle counter; expire flags the last BUSY cycle allowed before a timeout.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory sequencer: freezes the pipeline while a req/ack access is
// outstanding and presents load data during the single release (DONE) cycle.
module mem_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] addrM,
  input  logic [DATA_WIDTH-1:0] wdataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stop,
  output logic [DATA_WIDTH-1:0] rdataM,
  output logic                  mem_err
);

  mem_state_t            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_err_q, mem_err_d;
  logic                  access;
  logic                  stop_c;
  logic                  cnt_clear, cnt_en, cnt_expire;

  // A store wins when both controls are high, since mem_we latches MemWriteM.
  assign access = MemReadM | MemWriteM;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expire (cnt_expire)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_err_d   = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    stop_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stop_c      = 1'b1;
          mem_addr_d  = addrM;
          mem_wdata_d = wdataM;
          mem_we_d    = MemWriteM;
          mem_req_d   = 1'b1;
          cnt_clear   = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        stop_c = 1'b1;
        cnt_en = 1'b1;
        // An ack in the final allowed cycle beats the timeout.
        if (mem_ack) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_expire) begin
          if (!mem_we_q) rdata_d = '0;
          mem_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      // Release cycle: the frozen instruction advances, so its still-high
      // access controls must not start a second transaction.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdataM    = rdata_q;
  assign mem_err   = mem_err_q;
  assign stop      = stop_c;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: transaction-level model of each access predicts every cycle's outputs.
module tb_mem_stall_ctrl;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemReadM, MemWriteM;
  logic [AW-1:0] addrM;
  logic [DW-1:0] wdataM;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stop;
  logic [DW-1:0] rdataM;
  logic          mem_err;

  always #5 clk = ~clk;

  mem_stall_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stop      (stop),
    .rdataM    (rdataM),
    .mem_err   (mem_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: expected outputs for the current cycle.
  logic          chk_en = 1'b0;
  logic          e_stop, e_req, e_err;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stop",      32'(stop),      32'(e_stop));
      chk("mem_req",   32'(mem_req),   32'(e_req));
      chk("mem_err",   32'(mem_err),   32'(e_err));
      chk("mem_we",    32'(mem_we),    32'(m_we));
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("rdataM",    32'(rdataM),    32'(m_rdata));
    end
  end

  // Observed timing facts used by the literal checks.
  int   cyc_n = 0, run = 0, last_run = 0, rise_cyc = 0, req_len = 0, err_cnt = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    cyc_n++;
    if (stop) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (mem_req && !prev_req) rise_cyc = cyc_n;
    if (!mem_req && prev_req) req_len = cyc_n - rise_cyc;
    if (mem_err) err_cnt++;
    prev_req = mem_req;
  end

  task automatic cyc(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic ack, input logic [DW-1:0] rdat,
                     input logic es, input logic er, input logic ee);
    @(posedge clk); #1;
    MemReadM  = rd;
    MemWriteM = wr;
    addrM     = a;
    wdataM    = wd;
    mem_ack   = ack;
    mem_rdata = rdat;
    e_stop    = es;
    e_req     = er;
    e_err     = ee;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom),
          1'b0, 1'b0, 1'b0);
  endtask

  // One memory instruction; lat = BUSY cycle carrying the ack, lat > TO means no ack.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int lat, input logic [DW-1:0] rdat);
    int last;
    last = (lat <= TO) ? lat : TO;
    cyc(rd, wr, a, wd, 1'($urandom_range(0, 1)), DW'($urandom), 1'b1, 1'b0, 1'b0);
    m_addr  = a;
    m_wdata = wd;
    m_we    = wr;
    for (int j = 1; j <= last; j++)
      cyc(rd, wr, a, wd, (j == lat), (j == lat) ? rdat : DW'($urandom), 1'b1, 1'b1, 1'b0);
    if (!wr) m_rdata = (lat <= TO) ? rdat : '0;
    cyc(rd, wr, a, wd, 1'($urandom_range(0, 1)), DW'($urandom), 1'b0, 1'b0, (lat > TO));
  endtask

  initial begin
    int e0, d1, kind;
    rst = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; addrM = '0; wdataM = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    e_stop = 1'b0; e_req = 1'b0; e_err = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;

    @(negedge clk);
    chk("rst_req",   32'(mem_req),   0);
    chk("rst_we",    32'(mem_we),    0);
    chk("rst_addr",  32'(mem_addr),  0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdataM),    0);
    chk("rst_err",   32'(mem_err),   0);
    chk("rst_stop",  32'(stop),      0);
    @(posedge clk); #3;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    access(1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF);
    chk("rd_stall_len", last_run, 3);
    chk("rd_req_len",   req_len, 2);
    chk("rd_rdata",     32'(rdataM), 32'h0000BEEF);
    idle(1);

    access(1'b0, 1'b1, 16'h0012, 16'h1234, 1, 16'h5555);
    chk("wr_stall_len", last_run, 2);
    chk("wr_rdata",     32'(rdataM), 32'h0000BEEF);
    idle(1);

    e0 = err_cnt;
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 9, 16'h7777);
    chk("to_req_len",   req_len, TO);
    chk("to_stall_len", last_run, TO + 1);
    chk("to_err_cnt",   err_cnt - e0, 1);
    chk("to_rdata",     32'(rdataM), 0);
    idle(1);

    e0 = err_cnt;
    access(1'b1, 1'b0, 16'h0200, 16'h0000, TO, 16'hA5A5);
    chk("co_rdata", 32'(rdataM), 32'h0000A5A5);
    chk("co_err",   err_cnt - e0, 0);
    idle(1);

    access(1'b1, 1'b0, 16'h0300, 16'h0000, 1, 16'h1111);
    d1 = cyc_n;
    access(1'b1, 1'b0, 16'h0302, 16'h0000, 3, 16'h2222);
    chk("b2b_gap", rise_cyc - d1, 2);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("stray_rdata", 32'(rdataM), 32'h00002222);

    // Reset while BUSY, then a late ack for the abandoned access.
    cyc(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    m_addr = 16'h0400; m_wdata = '0; m_we = 1'b0;
    cyc(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #3;
    e_stop = 1'b0; e_req = 1'b0; e_err = 1'b0;
    m_addr = '0; m_wdata = '0; m_we = 1'b0; m_rdata = '0;
    MemReadM = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_req",   32'(mem_req),  0);
    chk("arst_addr",  32'(mem_addr), 0);
    chk("arst_rdata", 32'(rdataM),   0);
    chk("arst_stop",  32'(stop),     0);
    @(negedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 16'h0400, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("late_ack_rdata", 32'(rdataM), 0);
    access(1'b1, 1'b0, 16'h0500, 16'h0000, 3, 16'hC0DE);
    chk("post_rst_rdata", 32'(rdataM), 32'h0000C0DE);
    idle(1);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      access((kind != 1), (kind != 0), AW'($urandom), DW'($urandom),
             $urandom_range(1, TO + 2), DW'($urandom));
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
